// File: rtl/elevator_ctrl.sv
// elevator_ctrl
//   Request scheduler and motion sequencer for a small elevator car.
//   Active-low car and hall buttons are latched into a pending-request
//   register. Direction is chosen with direction-hold (SCAN) logic: the car
//   keeps going while requests remain ahead of it, then reverses. A single
//   down-counter times both floor-to-floor travel and door dwell.
//
// Ports
//   clk         in   1         system clock, rising edge
//   rst_n       in   1         synchronous active-low reset
//   car_btn_n   in   N_FLOORS  car-panel buttons, active low, bit i = floor i
//   hall_btn_n  in   N_FLOORS  hall call buttons, active low, bit i = floor i
//   floor_idx   out  FW        current floor index
//   floor_code  out  3         floor_idx + 1 (floor 0 -> 3'b001)
//   motor_up    out  1         car moving up
//   motor_dn    out  1         car moving down
//   door_open   out  1         door open
//   req_lamp    out  N_FLOORS  pending request per floor
//   busy        out  1         controller not idle
module elevator_ctrl #(
  parameter int N_FLOORS   = 4,
  parameter int MOVE_TICKS = 50,
  parameter int DOOR_TICKS = 100,
  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] car_btn_n,
  input  logic [N_FLOORS-1:0] hall_btn_n,
  output logic [FW-1:0]       floor_idx,
  output logic [2:0]          floor_code,
  output logic                motor_up,
  output logic                motor_dn,
  output logic                door_open,
  output logic [N_FLOORS-1:0] req_lamp,
  output logic                busy
);

  localparam int MAX_T = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] MOVE_T = TW'(MOVE_TICKS);
  localparam logic [TW-1:0] DOOR_T = TW'(DOOR_TICKS);

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_ARRIVE, ST_DOOR} state_e;
  typedef enum logic {DIR_UP, DIR_DN} dir_e;

  state_e              state_q, state_d;
  dir_e                dir_q,   dir_d;
  logic [FW-1:0]       cur_q,   cur_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_FLOORS-1:0] req_q,   req_d;

  logic [N_FLOORS-1:0] btn;
  logic                above, below, here, ahead, behind;

  assign btn = ~car_btn_n | ~hall_btn_n;

  // Requests strictly above / below the car. At the end floors one side is
  // empty by construction, so no decision can drive the car off the shaft.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FW'(i) > cur_q) above = above | req_q[i];
      if (FW'(i) < cur_q) below = below | req_q[i];
    end
  end

  assign here   = req_q[cur_q];
  assign ahead  = (dir_q == DIR_UP) ? above : below;
  assign behind = (dir_q == DIR_UP) ? below : above;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      cur_q   <= '0;
      timer_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cur_q   <= cur_d;
      timer_q <= timer_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned and no
    // latch is inferred.
    state_d = state_q;
    dir_d   = dir_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    req_d   = req_q | btn;

    unique case (state_q)
      // IDLE and ARRIVE take the same decision; they differ only in how they
      // were entered. Keeping direction while work lies ahead, otherwise
      // reversing toward work behind, is the SCAN direction-hold rule.
      ST_IDLE, ST_ARRIVE: begin
        timer_d = '0;
        state_d = ST_IDLE;
        if (here) begin
          state_d = ST_DOOR;
          timer_d = DOOR_T;
        end else if (ahead) begin
          state_d = ST_MOVE;
          timer_d = MOVE_T;
        end else if (behind) begin
          state_d = ST_MOVE;
          timer_d = MOVE_T;
          dir_d   = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
        end
      end

      ST_MOVE: begin
        if (timer_q == TW'(1)) begin
          state_d = ST_ARRIVE;
          timer_d = '0;
          cur_d   = (dir_q == DIR_UP) ? cur_q + FW'(1) : cur_q - FW'(1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_DOOR: begin
        // A press at the open floor extends the dwell instead of queueing.
        req_d[cur_q] = 1'b0;
        if (btn[cur_q]) begin
          timer_d = DOOR_T;
        end else if (timer_q == TW'(1)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase
  end

  // Output decode; all outputs are functions of registered state only.
  always_comb begin
    floor_idx  = cur_q;
    floor_code = 3'(cur_q) + 3'd1;
    motor_up   = (state_q == ST_MOVE) && (dir_q == DIR_UP);
    motor_dn   = (state_q == ST_MOVE) && (dir_q == DIR_DN);
    door_open  = (state_q == ST_DOOR);
    req_lamp   = req_q;
    busy       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl
//   Bench for elevator_ctrl with MOVE_TICKS=4, DOOR_TICKS=3. A behavioural
//   model (floor, signed direction, remaining-cycle count, pending set) is
//   stepped on every rising edge; one negedge process compares every DUT
//   output against it. Directed scenarios add hand-computed expectations,
//   followed by a randomized run.
module tb_elevator_ctrl;

  localparam int N  = 4;
  localparam int MT = 4;
  localparam int DT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] car_btn_n;
  logic [N-1:0] hall_btn_n;
  logic [1:0]   floor_idx;
  logic [2:0]   floor_code;
  logic         motor_up, motor_dn, door_open, busy;
  logic [N-1:0] req_lamp;

  always #5 clk = ~clk;

  elevator_ctrl #(.N_FLOORS(N), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .car_btn_n  (car_btn_n),
    .hall_btn_n (hall_btn_n),
    .floor_idx  (floor_idx),
    .floor_code (floor_code),
    .motor_up   (motor_up),
    .motor_dn   (motor_dn),
    .door_open  (door_open),
    .req_lamp   (req_lamp),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_RUN = 1, P_STOP = 2, P_DOOR = 3;
  int       m_floor, m_dir, m_phase, m_left;
  bit [N-1:0] m_pend;

  // Any pending floor strictly beyond the car in direction d (+1 / -1).
  function automatic bit pend_toward(input int d);
    for (int f = m_floor + d; f >= 0 && f < N; f += d)
      if (m_pend[f]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit [N-1:0] press;
    bit [N-1:0] nxt;
    press = ~car_btn_n | ~hall_btn_n;
    if (!rst_n) begin
      m_floor = 0; m_dir = 1; m_phase = P_IDLE; m_left = 0; m_pend = '0;
    end else begin
      nxt = m_pend | press;
      case (m_phase)
        P_IDLE, P_STOP: begin
          m_phase = P_IDLE;
          if (m_pend[m_floor]) begin
            m_phase = P_DOOR; m_left = DT;
          end else if (pend_toward(m_dir)) begin
            m_phase = P_RUN; m_left = MT;
          end else if (pend_toward(-m_dir)) begin
            m_dir = -m_dir; m_phase = P_RUN; m_left = MT;
          end
        end
        P_RUN: begin
          m_left--;
          if (m_left == 0) begin
            m_floor += m_dir;
            m_phase = P_STOP;
          end
        end
        default: begin
          nxt[m_floor] = 1'b0;
          if (press[m_floor]) m_left = DT;
          else begin
            m_left--;
            if (m_left == 0) m_phase = P_IDLE;
          end
        end
      endcase
      m_pend = nxt;
    end
  end

  // ---------------- every-cycle compare ----------------
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("floor_idx",  32'(floor_idx),  32'(m_floor));
      check("floor_code", 32'(floor_code), 32'(m_floor + 1));
      check("motor_up",   32'(motor_up),   32'(m_phase == P_RUN && m_dir == 1));
      check("motor_dn",   32'(motor_dn),   32'(m_phase == P_RUN && m_dir == -1));
      check("door_open",  32'(door_open),  32'(m_phase == P_DOOR));
      check("busy",       32'(busy),       32'(m_phase != P_IDLE));
      check("req_lamp",   32'(req_lamp),   32'(m_pend));
      check("exclusive",  32'($countones({motor_up, motor_dn, door_open}) <= 1), 32'd1);
    end
  end

  // ---------------- activity tally for directed checks ----------------
  int   cnt_up, cnt_dn, cnt_door;
  int   door_q[$];
  logic prev_door = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      if (motor_up)  cnt_up++;
      if (motor_dn)  cnt_dn++;
      if (door_open) cnt_door++;
      if (door_open && !prev_door) door_q.push_back(int'(floor_idx));
      prev_door = door_open;
    end
  end

  task automatic clr_tally();
    cnt_up = 0; cnt_dn = 0; cnt_door = 0;
    door_q.delete();
  endtask

  // Drive the masked buttons low for one cycle; returns on the next negedge.
  task automatic press(input logic [N-1:0] car_m, input logic [N-1:0] hall_m);
    car_btn_n  = ~car_m;
    hall_btn_n = ~hall_m;
    @(negedge clk);
    car_btn_n  = '1;
    hall_btn_n = '1;
  endtask

  task automatic wait_quiet(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && req_lamp === '0) done = 1'b1;
    end
    check("quiet_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    car_btn_n  = '1;
    hall_btn_n = '1;
    clr_tally();

    // 1: reset for two cycles
    @(negedge clk);
    @(negedge clk);
    check("rst_floor_code", 32'(floor_code), 32'b001);
    check("rst_floor_idx",  32'(floor_idx),  32'd0);
    check("rst_motors",     32'({motor_up, motor_dn}), 32'd0);
    check("rst_door",       32'(door_open),  32'd0);
    check("rst_lamps",      32'(req_lamp),   32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 2: floor 0 -> floor 2, passing floor 1 without stopping
    clr_tally();
    press(4'b0100, 4'b0000);
    check("s2_lamp", 32'(req_lamp), 32'b0100);
    wait_quiet(200);
    check("s2_up_cycles",   32'(cnt_up),   32'd8);
    check("s2_dn_cycles",   32'(cnt_dn),   32'd0);
    check("s2_door_cycles", 32'(cnt_door), 32'd3);
    check("s2_stops",       32'(door_q.size()), 32'd1);
    if (door_q.size() > 0) check("s2_stop_floor", 32'(door_q[0]), 32'd2);
    check("s2_floor_code",  32'(floor_code), 32'b011);

    // 3: go to floor 1 (car heading down), then call 3 and, while moving up, 0
    press(4'b0010, 4'b0000);
    wait_quiet(200);
    clr_tally();
    press(4'b1000, 4'b0000);
    @(negedge clk);
    press(4'b0000, 4'b0001);
    wait_quiet(400);
    check("s3_up_cycles", 32'(cnt_up), 32'd8);
    check("s3_dn_cycles", 32'(cnt_dn), 32'd12);
    check("s3_stops",     32'(door_q.size()), 32'd2);
    if (door_q.size() == 2) begin
      check("s3_first_stop",  32'(door_q[0]), 32'd3);
      check("s3_second_stop", 32'(door_q[1]), 32'd0);
    end

    // 4: idle at floor 1, hall call at the car's floor, re-press on door cycle 2
    press(4'b0010, 4'b0000);
    wait_quiet(200);
    clr_tally();
    press(4'b0000, 4'b0010);
    check("s4_door_early", 32'(door_open), 32'd0);
    @(negedge clk);
    check("s4_door_open", 32'(door_open), 32'd1);
    @(negedge clk);
    press(4'b0000, 4'b0010);
    check("s4_no_relatch", 32'(req_lamp[1]), 32'd0);
    wait_quiet(200);
    check("s4_door_cycles", 32'(cnt_door), 32'd5);
    check("s4_no_motion",   32'(cnt_up + cnt_dn), 32'd0);

    // 5: reset in MOVE cycle 3 toward floor 2
    press(4'b0100, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("s5_moving", 32'(motor_up), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("s5_floor_code", 32'(floor_code), 32'b001);
    check("s5_motor_up",   32'(motor_up),   32'd0);
    check("s5_lamps",      32'(req_lamp),   32'd0);
    check("s5_busy",       32'(busy),       32'd0);
    rst_n = 1'b1;

    // 6: every button at once from floor 0
    clr_tally();
    press(4'b1111, 4'b1111);
    wait_quiet(400);
    check("s6_stops", 32'(door_q.size()), 32'd4);
    for (int i = 0; i < door_q.size() && i < 4; i++)
      check("s6_stop_order", 32'(door_q[i]), 32'(i));
    check("s6_up_cycles", 32'(cnt_up), 32'd12);
    check("s6_lamps",     32'(req_lamp), 32'd0);

    // Randomized traffic, occasional held buttons and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        car_btn_n  = 4'($urandom) | 4'($urandom);
        hall_btn_n = 4'($urandom) | 4'($urandom);
      end else if ($urandom_range(0, 2) != 0) begin
        car_btn_n  = '1;
        hall_btn_n = '1;
      end
      rst_n = ($urandom_range(0, 799) != 0);
      @(negedge clk);
    end
    rst_n      = 1'b1;
    car_btn_n  = '1;
    hall_btn_n = '1;
    wait_quiet(1000);
    check("final_lamps", 32'(req_lamp), 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
